lh_msg_sender: RTL and testbench
================================

Name: lh_msg_sender

Overview:
- Transmit-side front end for the light-hash core.
- Accepts a message from a host one character at a time and buffers it.
- Frames the message onto the hasher's character interface: start byte 8'hFF, the characters, then finish byte 8'h00.
- Waits for the hasher's 64-bit digest and returns it to the host, with a timeout if it never arrives.

Parameters:
- DEPTH, 16, message buffer capacity in characters (power of 2, ≥2).
- TIMEOUT, 64, maximum number of cycles spent in WAIT_DIGEST before aborting.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- msg_char  input  8  host message character.
- msg_valid  input  1  msg_char valid.
- msg_last  input  1  qualifies msg_char as final character of the message.
- msg_ready  output  1  block accepts msg_char this cycle.
- ptxt_char  output  8  character to hasher.
- ptxt_valid  output  1  ptxt_char valid.
- digest_char  input  64  digest from hasher.
- digest_ready  input  1  digest_char valid.
- digest_out  output  64  last captured digest.
- digest_out_valid  output  1  one-cycle pulse when digest_out updates.
- busy  output  1  high in any state other than IDLE/LOAD.
- err_char  output  1  one-cycle pulse when an invalid host character is dropped.
- err_timeout  output  1  one-cycle pulse when the digest wait times out.

Behaviour:
- Reset, async on rst high:
  - State IDLE; buffer write/read pointers and count cleared.
  - All outputs 0: ptxt_char=8'h00, ptxt_valid=0, digest_out=64'h0, pulses 0, busy=0, msg_ready=0.
- FSM states: IDLE, LOAD, SEND_START, SEND_CHAR, SEND_FINISH, WAIT_DIGEST.
- IDLE:
  - msg_ready=1; go to LOAD on the first accepted handshake.
  - That first character is processed exactly as in LOAD.
- LOAD:
  - msg_ready=1 while count<DEPTH; a handshake is msg_valid && msg_ready.
  - Valid characters are 'A'-'Z', 'a'-'z' and '0'-'9'. Each is written at the write pointer and count increments.
  - Any other value, including 8'hFF and 8'h00, is not stored and err_char pulses on the next cycle. This guarantees framing bytes never appear as payload.
  - A handshake with msg_last=1 (valid or invalid character) moves to SEND_START.
  - When count reaches DEPTH without msg_last, move to SEND_START automatically; msg_ready drops the same cycle.
- SEND_START:
  - ptxt_char=8'hFF, ptxt_valid=1 for exactly one cycle.
  - Next state is SEND_CHAR if count>0, else SEND_FINISH (empty message allowed).
- SEND_CHAR:
  - One buffered character per cycle, in write order; ptxt_valid=1 continuously.
  - After the count-th character, go to SEND_FINISH.
- SEND_FINISH:
  - ptxt_char=8'h00, ptxt_valid=1 for one cycle.
  - Go to WAIT_DIGEST and clear the wait counter.
- All registered outputs: ptxt_char/ptxt_valid are registers.
- Timing: with msg_last accepted at edge T and N stored characters:
  - 8'hFF is visible in cycle T+1.
  - Characters in cycles T+2..T+1+N.
  - 8'h00 in cycle T+2+N.
- Outside the SEND states, ptxt_valid=0 and ptxt_char=8'h00.
- WAIT_DIGEST:
  - On digest_ready=1, capture digest_char into digest_out, pulse digest_out_valid next cycle, clear the buffer, go to IDLE.
  - The counter increments every cycle. When it reaches TIMEOUT-1 without digest_ready, pulse err_timeout, leave digest_out unchanged, clear the buffer, go to IDLE.
  - If digest_ready arrives in the same cycle the counter hits TIMEOUT-1, the digest wins and no timeout is flagged.
- digest_ready is ignored in all states other than WAIT_DIGEST.
- msg_ready=0 in all busy states; host characters offered there are neither stored nor flagged.
- Reset mid-operation aborts immediately. No finish byte is emitted and the partial buffer is discarded.

Test Plan:
- Send "Ab1" (8'h41, 8'h62, 8'h31 with last) -> ptxt stream FF,41,62,31,00 on consecutive cycles. Then digest_ready with 64'h0123456789ABCDEF after 5 cycles -> digest_out=64'h0123456789ABCDEF, digest_out_valid single pulse, return to IDLE.
- Send 'A', '#'(8'h23), 8'hFF, 'z' with last -> err_char pulses twice; stream FF,41,7A,00.
- 16 valid characters with no msg_last (DEPTH=16) -> msg_ready low after the 16th; stream is FF, 16 characters, 00 (18 cycles).
- Single invalid character with msg_last -> err_char pulse; stream FF,00 only; digest handling normal.
- No digest_ready after finish -> err_timeout pulses exactly 64 cycles after entering WAIT_DIGEST; digest_out retains its prior value. Repeat with digest_ready on cycle 63 -> digest captured, no err_timeout.
- Assert rst during SEND_CHAR of a 10-char message -> ptxt_valid=0 asynchronously, no 00 byte. A new 1-char message afterwards produces FF,c,00 with no leftover characters.

Source files
------------

// File: rtl/lh_msg_sender.sv
// Transmit-side front end for the light-hash core: buffers a host message, frames it
// as FF, payload, 00 onto the hasher character port, then waits (bounded) for the digest.
module lh_msg_sender #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  msg_char,
  input  logic        msg_valid,
  input  logic        msg_last,
  output logic        msg_ready,
  output logic [7:0]  ptxt_char,
  output logic        ptxt_valid,
  input  logic [63:0] digest_char,
  input  logic        digest_ready,
  output logic [63:0] digest_out,
  output logic        digest_out_valid,
  output logic        busy,
  output logic        err_char,
  output logic        err_timeout
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND_START, SEND_CHAR, SEND_FINISH, WAIT_DIGEST
  } state_t;

  state_t          state;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   wait_cnt;

  logic            accept_c;
  logic            wr_en_c;
  logic [CW-1:0]   cnt_next_c;

  // Only alphanumerics are payload, so FF/00 framing bytes can never be mistaken for data.
  function automatic logic is_alnum(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) ||
           ((c >= 8'h61) && (c <= 8'h7A)) ||
           ((c >= 8'h30) && (c <= 8'h39));
  endfunction

  assign accept_c   = msg_valid && msg_ready && ((state == IDLE) || (state == LOAD));
  assign wr_en_c    = accept_c && is_alnum(msg_char);
  assign cnt_next_c = count + CW'(wr_en_c);

  // Message storage; contents need no reset since pointers/count define what is live.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_ptr] <= msg_char;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      wait_cnt         <= '0;
      msg_ready        <= 1'b0;
      ptxt_char        <= 8'h00;
      ptxt_valid       <= 1'b0;
      digest_out       <= 64'h0;
      digest_out_valid <= 1'b0;
      busy             <= 1'b0;
      err_char         <= 1'b0;
      err_timeout      <= 1'b0;
    end else begin
      err_char         <= 1'b0;
      digest_out_valid <= 1'b0;
      err_timeout      <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (accept_c) begin
            if (wr_en_c) begin
              wr_ptr <= wr_ptr + AW'(1);
              count  <= cnt_next_c;
            end else begin
              err_char <= 1'b1;
            end
            // Last character or a full buffer closes the message; start byte goes out next cycle.
            if (msg_last || (cnt_next_c == CW'(DEPTH))) begin
              state      <= SEND_START;
              msg_ready  <= 1'b0;
              busy       <= 1'b1;
              ptxt_char  <= 8'hFF;
              ptxt_valid <= 1'b1;
            end else begin
              state     <= LOAD;
              msg_ready <= 1'b1;
            end
          end else begin
            msg_ready <= 1'b1;
          end
        end
        SEND_START, SEND_CHAR: begin
          if (count != '0) begin
            ptxt_char <= mem_q[rd_ptr];
            rd_ptr    <= rd_ptr + AW'(1);
            count     <= count - CW'(1);
            state     <= SEND_CHAR;
          end else begin
            ptxt_char <= 8'h00;
            state     <= SEND_FINISH;
          end
        end
        SEND_FINISH: begin
          ptxt_char  <= 8'h00;
          ptxt_valid <= 1'b0;
          wait_cnt   <= '0;
          state      <= WAIT_DIGEST;
        end
        WAIT_DIGEST: begin
          // Digest takes priority over a coincident timeout.
          if (digest_ready || (wait_cnt == TW'(TIMEOUT - 1))) begin
            if (digest_ready) begin
              digest_out       <= digest_char;
              digest_out_valid <= 1'b1;
            end else begin
              err_timeout <= 1'b1;
            end
            state     <= IDLE;
            busy      <= 1'b0;
            msg_ready <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lh_msg_sender.sv
// Randomised scoreboard bench for lh_msg_sender: a driver pushes expected frames/digests,
// an independent negedge monitor pops and compares whatever the DUT emits.
module tb_lh_msg_sender;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  msg_char;
  logic        msg_valid;
  logic        msg_last;
  logic        msg_ready;
  logic [7:0]  ptxt_char;
  logic        ptxt_valid;
  logic [63:0] digest_char;
  logic        digest_ready;
  logic [63:0] digest_out;
  logic        digest_out_valid;
  logic        busy;
  logic        err_char;
  logic        err_timeout;

  lh_msg_sender #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .rst              (rst),
    .msg_char         (msg_char),
    .msg_valid        (msg_valid),
    .msg_last         (msg_last),
    .msg_ready        (msg_ready),
    .ptxt_char        (ptxt_char),
    .ptxt_valid       (ptxt_valid),
    .digest_char      (digest_char),
    .digest_ready     (digest_ready),
    .digest_out       (digest_out),
    .digest_out_valid (digest_out_valid),
    .busy             (busy),
    .err_char         (err_char),
    .err_timeout      (err_timeout)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_ptxt[$];
  logic [63:0] exp_dig[$];
  int          exp_err_char = 0;
  int          seen_err_char = 0;
  int          exp_to = 0;
  int          seen_to = 0;
  logic [63:0] last_dig = 64'h0;
  bit          in_frame = 1'b0;
  logic [7:0]  mon_b;
  logic [63:0] mon_d;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit alnum(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A) || (c >= 8'h30 && c <= 8'h39);
  endfunction

  function automatic logic [7:0] rand_char();
    int unsigned k;
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    k = $urandom_range(0, 61);
    if (k < 26) return 8'(8'h41 + k);
    if (k < 52) return 8'(8'h61 + k - 26);
    return 8'(8'h30 + k - 52);
  endfunction

  // Monitor: every output event is matched against the scoreboard queues.
  always @(negedge clk) begin
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (in_frame) check("ptxt_contiguous", 64'(ptxt_valid), 64'(1));
      if (ptxt_valid) begin
        if (exp_ptxt.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ptxt_unexpected actual=%0h expected=none at %0t", ptxt_char, $time);
          in_frame = 1'b0;
        end else begin
          mon_b = exp_ptxt.pop_front();
          check("ptxt_char", 64'(ptxt_char), 64'(mon_b));
          in_frame = (mon_b != 8'h00);
        end
      end else begin
        in_frame = 1'b0;
      end
      if (digest_out_valid) begin
        if (exp_dig.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL digest_unexpected actual=%0h expected=none at %0t", digest_out, $time);
        end else begin
          mon_d = exp_dig.pop_front();
          check("digest_scoreboard", digest_out, mon_d);
        end
      end
      if (err_char) seen_err_char++;
      if (err_timeout) seen_to++;
    end
  end

  // Offer one character at a negedge; returns at the negedge after the accepting edge.
  task automatic offer(input logic [7:0] c, input bit last);
    int n = 0;
    msg_char  = c;
    msg_last  = last;
    msg_valid = 1'b1;
    while (!msg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("msg_ready_wait", 64'(msg_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    check("err_char_timing", 64'(err_char), 64'(!alnum(c)));
  endtask

  // Model: only alphanumerics are kept, the buffer closes at DEPTH, frame is FF + kept + 00.
  task automatic send_msg(input logic [7:0] msg[$], input bit use_last);
    logic [7:0] offered[$];
    logic [7:0] kept[$];
    foreach (msg[i]) begin
      if (kept.size() == DEPTH) break;
      offered.push_back(msg[i]);
      if (alnum(msg[i])) kept.push_back(msg[i]);
    end
    exp_ptxt.push_back(8'hFF);
    foreach (kept[i]) exp_ptxt.push_back(kept[i]);
    exp_ptxt.push_back(8'h00);
    exp_err_char += offered.size() - kept.size();
    foreach (offered[i]) offer(offered[i], use_last && (i == offered.size() - 1));
    check("start_byte_valid", 64'(ptxt_valid), 64'(1));
    check("start_byte", 64'(ptxt_char), 64'(8'hFF));
    check("busy_high", 64'(busy), 64'(1));
    check("msg_ready_low", 64'(msg_ready), 64'(0));
  endtask

  // Answer the frame with a digest d cycles into the wait, or let it time out (d >= TIMEOUT).
  task automatic finish_digest(input int d, input logic [63:0] val);
    int n = 0;
    while (!(ptxt_valid && ptxt_char == 8'h00) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("finish_seen", 64'(ptxt_valid && ptxt_char == 8'h00), 64'(1));
    msg_char  = 8'h23;
    msg_valid = 1'b1;
    if (d >= int'(TIMEOUT)) begin
      n = 0;
      while (n == 0 || (!err_timeout && n < 80)) begin
        @(negedge clk);
        n++;
      end
      msg_valid = 1'b0;
      exp_to++;
      check("timeout_latency", 64'(n), 64'(TIMEOUT + 1));
      check("digest_held", digest_out, last_dig);
    end else begin
      repeat (d + 1) @(negedge clk);
      msg_valid    = 1'b0;
      digest_char  = val;
      digest_ready = 1'b1;
      exp_dig.push_back(val);
      @(negedge clk);
      digest_ready = 1'b0;
      digest_char  = {$urandom, $urandom};
      check("digest_pulse", 64'(digest_out_valid), 64'(1));
      check("digest_value", digest_out, val);
      last_dig = val;
    end
    repeat (2) @(negedge clk);
    check("idle_not_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    rst = 1'b1;
    msg_char = 8'h00; msg_valid = 1'b0; msg_last = 1'b0;
    digest_char = 64'h0; digest_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ptxt_valid", 64'(ptxt_valid), 64'(0));
    check("rst_ptxt_char", 64'(ptxt_char), 64'(0));
    check("rst_digest_out", digest_out, 64'h0);
    check("rst_pulses", 64'({digest_out_valid, err_char, err_timeout}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_msg_ready", 64'(msg_ready), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(msg_ready), 64'(1));

    q = '{8'h41, 8'h62, 8'h31};
    send_msg(q, 1'b1);
    finish_digest(5, 64'h0123456789ABCDEF);

    digest_ready = 1'b1;
    digest_char  = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    digest_ready = 1'b0;
    @(negedge clk);
    check("digest_ignored_idle", 64'(digest_out_valid), 64'(0));
    check("digest_kept_idle", digest_out, last_dig);

    q = '{8'h41, 8'h23, 8'hFF, 8'h7A};
    send_msg(q, 1'b1);
    finish_digest(int'($urandom_range(0, 20)), {$urandom, $urandom});

    q = {};
    for (int i = 0; i < int'(DEPTH); i++) begin
      logic [7:0] c;
      c = rand_char();
      while (!alnum(c)) c = rand_char();
      q.push_back(c);
    end
    send_msg(q, 1'b0);
    finish_digest(2, {$urandom, $urandom});

    q = '{8'h2E};
    send_msg(q, 1'b1);
    finish_digest(3, {$urandom, $urandom});

    q = '{8'h48, 8'h69};
    send_msg(q, 1'b1);
    finish_digest(int'(TIMEOUT), 64'h0);
    send_msg(q, 1'b1);
    finish_digest(int'(TIMEOUT) - 1, 64'hFEDC_BA98_7654_3210);

    q = {};
    for (int i = 0; i < 10; i++) q.push_back(8'(8'h61 + i));
    send_msg(q, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_ptxt.delete();
    #1;
    check("async_rst_ptxt_valid", 64'(ptxt_valid), 64'(0));
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_digest", digest_out, 64'h0);
    last_dig = 64'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q = '{8'h51};
    send_msg(q, 1'b1);
    finish_digest(4, {$urandom, $urandom});

    for (int m = 0; m < 25; m++) begin
      int len;
      int d;
      len = int'($urandom_range(1, 20));
      q = {};
      for (int i = 0; i < len; i++) q.push_back(rand_char());
      d = ($urandom_range(0, 7) == 0) ? int'(TIMEOUT) : int'($urandom_range(0, 12));
      send_msg(q, 1'b1);
      finish_digest(d, {$urandom, $urandom});
    end

    repeat (5) @(negedge clk);
    check("err_char_count", 64'(seen_err_char), 64'(exp_err_char));
    check("err_timeout_count", 64'(seen_to), 64'(exp_to));
    check("ptxt_queue_drained", 64'(exp_ptxt.size()), 64'(0));
    check("digest_queue_drained", 64'(exp_dig.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
